// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the program-counter fetch sequencer.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/pc_target_add.sv
// Branch target adder: branch_pc plus the half-word immediate scaled to bytes.
// Only the low ADDR_W bits of the sum are produced, so the target wraps naturally.
module pc_target_add #(
  parameter int ADDR_W = 8,
  parameter int IMM_W  = 64
) (
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic [IMM_W-1:0]  imm,
  output logic [ADDR_W-1:0] tgt
);

  // Immediate bits above the PC width cannot affect a truncated sum.
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[IMM_W-1:ADDR_W-1];

  assign tgt = branch_pc + {imm[ADDR_W-2:0], 1'b0};

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC sequencer: issues fetches with a ready handshake, redirects on taken
// branches with a one-cycle flush bubble, and halts on an accepted END_PC fetch.
module pc_fetch_ctrl #(
  parameter int                ADDR_W   = 8,
  parameter int                IMM_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter logic [ADDR_W-1:0] END_PC   = 8'hFC,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              branch,
  input  logic              zero_flag,
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic [IMM_W-1:0]  imm,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_valid,
  output logic              flush,
  output logic              halted,
  output logic              misalign,
  output logic [CNT_W-1:0]  fetch_count
);

  import pc_ctrl_pkg::*;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] tgt;
  logic              take;
  logic              accept;
  logic              cnt_inc;
  logic              cnt_clr;
  logic              set_mis;

  pc_target_add #(
    .ADDR_W (ADDR_W),
    .IMM_W  (IMM_W)
  ) u_target_add (
    .branch_pc (branch_pc),
    .imm       (imm),
    .tgt       (tgt)
  );

  assign take        = branch & zero_flag;
  assign fetch_valid = (state == RUN);
  assign flush       = (state == REDIR);
  assign halted      = (state == HALT);
  assign accept      = fetch_valid & imem_ready & ~stall;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    set_mis   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = RESET_PC;
        end
      end
      RUN: begin
        // A taken branch drops the outstanding request even if memory accepts it.
        if (take) begin
          state_nxt = REDIR;
          pc_nxt    = tgt;
          set_mis   = (tgt[1:0] != 2'b00);
        end else if (accept) begin
          cnt_inc = 1'b1;
          if (pc == END_PC) state_nxt = HALT;
          else              pc_nxt    = pc + ADDR_W'(PC_STEP);
        end
      end
      REDIR: state_nxt = RUN;
      HALT: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = RESET_PC;
          cnt_clr   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      misalign    <= 1'b0;
      fetch_count <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      misalign <= misalign | set_mis;
      if (cnt_clr)
        fetch_count <= '0;
      else if (cnt_inc && (fetch_count != {CNT_W{1'b1}}))
        fetch_count <= fetch_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scenario bench for pc_fetch_ctrl with END_PC=10; accepted fetch addresses
// are checked against a queue of expected PCs.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stall;
  logic        branch;
  logic        zero_flag;
  logic [7:0]  branch_pc;
  logic [63:0] imm;
  logic        imem_ready;
  logic [7:0]  pc;
  logic        fetch_valid;
  logic        flush;
  logic        halted;
  logic        misalign;
  logic [15:0] fetch_count;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  pc_fetch_ctrl #(
    .ADDR_W   (8),
    .IMM_W    (64),
    .RESET_PC (8'h00),
    .END_PC   (8'h10),
    .CNT_W    (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stall       (stall),
    .branch      (branch),
    .zero_flag   (zero_flag),
    .branch_pc   (branch_pc),
    .imm         (imm),
    .imem_ready  (imem_ready),
    .pc          (pc),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .halted      (halted),
    .misalign    (misalign),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: every fetch that will be accepted at the next edge pops one expected PC.
  always @(negedge clk) begin
    if (!reset && fetch_valid && imem_ready && !stall && !(branch && zero_flag)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow got_pc=%h want=none", pc);
      end else begin
        logic [7:0] want;
        want = exp_q.pop_front();
        if (pc !== want) begin
          bad++;
          $display("FAIL sb_fetch_pc got=%h want=%h", pc, want);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch = 1'b0; zero_flag = 1'b0;
    branch_pc = 8'h00; imm = 64'd0; imem_ready = 1'b0;
    tick(); tick();
    total++; if (pc !== 8'h00) begin bad++; $display("FAIL rst_pc got=%h want=00", pc); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rst_fv got=%b want=0", fetch_valid); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL rst_flush got=%b want=0", flush); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b want=0", halted); end
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL rst_mis got=%b want=0", misalign); end
    total++; if (fetch_count !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", fetch_count); end
    reset = 1'b0;
    tick();
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL idle_fv got=%b want=0", fetch_valid); end
  endtask

  task automatic test_sequential();
    imem_ready = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h04);
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (pc !== 8'h00 || fetch_valid !== 1'b1) begin bad++; $display("FAIL seq_start got=%h/%b want=00/1", pc, fetch_valid); end
    tick(); tick();
    imem_ready = 1'b0;
    total++; if (pc !== 8'h08) begin bad++; $display("FAIL seq_pc got=%h want=08", pc); end
    total++; if (fetch_count !== 16'd2) begin bad++; $display("FAIL seq_cnt got=%0d want=2", fetch_count); end
    tick(); tick();
    total++; if (pc !== 8'h08 || fetch_valid !== 1'b1) begin bad++; $display("FAIL wait_hold got=%h/%b want=08/1", pc, fetch_valid); end
  endtask

  task automatic test_not_taken();
    exp_q.push_back(8'h08);
    imem_ready = 1'b1;
    branch = 1'b1; zero_flag = 1'b0; branch_pc = 8'h04; imm = 64'd6;
    tick();
    branch = 1'b0;
    total++; if (pc !== 8'h0C) begin bad++; $display("FAIL nt_pc got=%h want=0C", pc); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL nt_flush got=%b want=0", flush); end
    total++; if (fetch_count !== 16'd3) begin bad++; $display("FAIL nt_cnt got=%0d want=3", fetch_count); end
  endtask

  task automatic test_stall_take();
    stall = 1'b1;
    tick();
    total++; if (pc !== 8'h0C) begin bad++; $display("FAIL stall_hold got=%h want=0C", pc); end
    branch = 1'b1; zero_flag = 1'b1; branch_pc = 8'h0C; imm = -64'sd2;
    tick();
    branch = 1'b0;
    total++; if (pc !== 8'h08 || flush !== 1'b1 || fetch_valid !== 1'b0)
      begin bad++; $display("FAIL stall_take got=%h/%b/%b want=08/1/0", pc, flush, fetch_valid); end
    tick();
    total++; if (pc !== 8'h08 || flush !== 1'b0 || fetch_valid !== 1'b1)
      begin bad++; $display("FAIL stall_redir_end got=%h/%b/%b want=08/0/1", pc, flush, fetch_valid); end
    stall = 1'b0;
    total++; if (fetch_count !== 16'd3) begin bad++; $display("FAIL stall_cnt got=%0d want=3", fetch_count); end
  endtask

  task automatic test_taken();
    branch = 1'b1; zero_flag = 1'b1; branch_pc = 8'h04; imm = 64'd6;
    tick();
    total++; if (pc !== 8'h10 || flush !== 1'b1 || fetch_valid !== 1'b0)
      begin bad++; $display("FAIL take_redir got=%h/%b/%b want=10/1/0", pc, flush, fetch_valid); end
    branch_pc = 8'h00; imm = 64'd1;
    tick();
    branch = 1'b0;
    total++; if (pc !== 8'h10 || flush !== 1'b0 || fetch_valid !== 1'b1 || misalign !== 1'b0)
      begin bad++; $display("FAIL redir_ignore got=%h/%b/%b/%b want=10/0/1/0", pc, flush, fetch_valid, misalign); end
    exp_q.push_back(8'h10);
    tick();
    total++; if (halted !== 1'b1 || pc !== 8'h10 || fetch_valid !== 1'b0)
      begin bad++; $display("FAIL end_halt got=%b/%h/%b want=1/10/0", halted, pc, fetch_valid); end
    total++; if (fetch_count !== 16'd4) begin bad++; $display("FAIL end_cnt got=%0d want=4", fetch_count); end
  endtask

  task automatic test_halt_restart();
    branch = 1'b1; zero_flag = 1'b1; branch_pc = 8'h00; imm = 64'd1;
    tick();
    branch = 1'b0;
    total++; if (pc !== 8'h10 || halted !== 1'b1 || misalign !== 1'b0)
      begin bad++; $display("FAIL halt_branch got=%h/%b/%b want=10/1/0", pc, halted, misalign); end
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(4 * i));
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (pc !== 8'h00 || fetch_count !== 16'd0 || halted !== 1'b0 || fetch_valid !== 1'b1)
      begin bad++; $display("FAIL restart got=%h/%0d/%b/%b want=00/0/0/1", pc, fetch_count, halted, fetch_valid); end
    for (int i = 0; i < 5; i++) tick();
    total++; if (halted !== 1'b1 || fetch_count !== 16'd5 || pc !== 8'h10)
      begin bad++; $display("FAIL run_halt got=%b/%0d/%h want=1/5/10", halted, fetch_count, pc); end
  endtask

  task automatic test_coincide_misalign();
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(4 * i));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    branch = 1'b1; zero_flag = 1'b1; branch_pc = 8'h00; imm = 64'd1;
    tick();
    branch = 1'b0;
    total++; if (pc !== 8'h02 || flush !== 1'b1 || halted !== 1'b0)
      begin bad++; $display("FAIL coincide got=%h/%b/%b want=02/1/0", pc, flush, halted); end
    total++; if (misalign !== 1'b1) begin bad++; $display("FAIL mis_set got=%b want=1", misalign); end
    total++; if (fetch_count !== 16'd4) begin bad++; $display("FAIL coincide_cnt got=%0d want=4", fetch_count); end
    imem_ready = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (pc !== 8'h02 || fetch_valid !== 1'b1 || misalign !== 1'b1)
      begin bad++; $display("FAIL start_in_run got=%h/%b/%b want=02/1/1", pc, fetch_valid, misalign); end
  endtask

  task automatic test_reset_redir();
    branch = 1'b1; zero_flag = 1'b1; branch_pc = 8'h00; imm = 64'd2;
    tick();
    branch = 1'b0;
    total++; if (pc !== 8'h04 || flush !== 1'b1) begin bad++; $display("FAIL pre_rst_redir got=%h/%b want=04/1", pc, flush); end
    reset = 1'b1;
    #1;
    total++; if (pc !== 8'h00 || flush !== 1'b0 || fetch_valid !== 1'b0 || misalign !== 1'b0)
      begin bad++; $display("FAIL async_rst got=%h/%b/%b/%b want=00/0/0/0", pc, flush, fetch_valid, misalign); end
    tick();
    reset = 1'b0;
    tick();
    total++; if (flush !== 1'b0 || fetch_valid !== 1'b0 || halted !== 1'b0)
      begin bad++; $display("FAIL post_rst_idle got=%b/%b/%b want=0/0/0", flush, fetch_valid, halted); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_not_taken();
    test_stall_take();
    test_taken();
    test_halt_restart();
    test_coincide_misalign();
    test_reset_redir();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter sequencer for the single-issue core. It owns the 8-bit PC register and issues fetch requests to instruction memory with a ready handshake. It resolves taken branches from execute (branch AND zero_flag) into a PC redirect with a flush pulse, and stops at a programmed end address. It sits between the execute-stage branch outputs and the instruction-memory address port, and replaces the free-running PC+4/branch mux.

## Interface
Parameters:
- ADDR_W, 8, PC width; all PC arithmetic is modulo 2^ADDR_W
- IMM_W, 64, immediate width from immgen
- RESET_PC, 8'h00, PC loaded at reset and on start
- END_PC, 8'hFC, address whose accepted fetch halts the sequencer
- CNT_W, 16, fetch-counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle pulse; leaves IDLE or HALT
- stall  in  1  decode hazard; holds the PC and blocks acceptance
- branch  in  1  execute-stage branch control
- zero_flag  in  1  ALU zero result for the same instruction
- branch_pc  in  ADDR_W  PC of the resolving branch instruction
- imm  in  IMM_W  sign-extended branch immediate, in half-word units
- imem_ready  in  1  instruction memory accepts the current request
- pc  out  ADDR_W  fetch address, registered
- fetch_valid  out  1  pc is a live request this cycle
- flush  out  1  one-cycle pulse; younger in-flight instructions are killed
- halted  out  1  high in HALT
- misalign  out  1  sticky; a redirect target had bits[1:0] != 0
- fetch_count  out  CNT_W  accepted fetches, saturating at all-ones

## Operation
- Taken condition: take = branch & zero_flag.
- Target: tgt = (branch_pc + {imm[IMM_W-2:0],1'b0})[ADDR_W-1:0]. Upper immediate bits are discarded and the result wraps mod 256.
- Sequential step: pc + 4, wrapping 8'hFC -> 8'h00.
- Accept = fetch_valid & imem_ready & ~stall.
- FSM states:
  - IDLE: fetch_valid=0. On start: pc<=RESET_PC, go to RUN.
  - RUN: fetch_valid=1.
    - If take: pc<=tgt, go to REDIR. take has priority over stall and accept, and the current request is dropped.
    - Else if accept and pc==END_PC: go to HALT, pc holds.
    - Else if accept: pc<=pc+4.
    - Else: hold.
  - REDIR: fetch_valid=0, flush=1 for exactly this cycle; go to RUN unconditionally. Branches arriving in REDIR are ignored.
  - HALT: fetch_valid=0, halted=1. branch is ignored. On start: pc<=RESET_PC, fetch_count<=0, go to RUN.
- misalign is set when a redirect is taken with tgt[1:0]!=0. The target is still loaded. It is cleared only by reset.
- fetch_count increments on each accept and saturates.

## Timing
- Reset (async assert, synchronous release edge): state=IDLE, pc=RESET_PC, fetch_valid=0, flush=0, halted=0, misalign=0, fetch_count=0.
- All outputs are registered or decoded from state. There are no input-to-output combinational paths.
- Redirect latency: take sampled at edge N -> pc=tgt and flush=1 after N. The first fetch of tgt is visible after N+1, a one-bubble penalty.
- An imem_ready held low keeps the request stable: pc and fetch_valid do not change until accept or take.
- If take and accept coincide at END_PC, the redirect wins and there is no halt.
- If reset asserts mid-REDIR or mid-wait, the block returns to IDLE immediately. No flush pulse is emitted after reset.
- start in RUN or REDIR is ignored.

## Structure
- Package pc_ctrl_pkg holds the state enum (IDLE, RUN, REDIR, HALT; 2-bit encoding) and the PC_STEP=4 constant.
- Sub-module pc_target_add: a combinational branch_pc + (imm<<1) adder with truncated output, instantiated once.
- FSM, PC register, sticky flag and counter live in the top.

## Test plan
- Reset then start, imem_ready=1, no branches -> pc sequence 00,04,08,…; fetch_count=3 after three accepts.
- At pc=08, branch=1, zero_flag=1, branch_pc=04, imm=6 -> next pc=10, flush high one cycle, fetch_valid=0 that cycle, then fetch of 10.
- branch=1, zero_flag=0 at pc=08 -> no redirect, pc=0C, flush never asserted.
- stall=1 for 3 cycles at pc=0C with take asserted on the 2nd cycle, branch_pc=0C, imm=-2 -> pc=08 next cycle, flush pulse; without take, pc holds at 0C.
- END_PC=10, run from 00 -> halted=1 after accepting 10, fetch_count=5, pc=10; start -> pc=00, count=0, RUN.
- Redirect with imm=1 from branch_pc=00 -> pc=02, misalign=1 and stays set; assert reset mid-REDIR -> IDLE, pc=00, misalign=0.
